pcie_msi_scheduler: RTL



---
 rtl/pcie_irq_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/pcie_msi_scheduler.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pcie_irq_pkg.sv
// Shared constants for the interrupt blocks: MSI FSM state codes and MSI vector sizing.
package pcie_irq_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam int MSI_VEC_W = 5;
    localparam int MAX_IRQ   = 32;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping at N-1.
// Zero latency; no backpressure (pure function of req and ptr).
module rr_arbiter #(
    parameter int N  = 8,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] grant,
    output logic          grant_vld
);
    logic [PW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit is the last one written.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = PW'((int'(ptr) + i) % N);
            if (req[cand]) begin
                grant     = cand;
                grant_vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/pcie_msi_scheduler.sv
// Round-robin MSI scheduler sharing one bridge MSI handshake among IRQ_COUNT sources.
// Latency: IRQ_IN edge -> PENDING next cycle -> MSI_REQ the cycle after; REQ held until SENT/FAIL.
// Optional ack timeout with sticky TIMEOUT_ERR when MSI_TIMEOUT_EN is defined.
module pcie_msi_scheduler
    import pcie_irq_pkg::*;
#(
    parameter int IRQ_COUNT      = 8,
    parameter int HOLDOFF_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IRQ_COUNT-1:0]  IRQ_IN,
    input  logic [IRQ_COUNT-1:0]  IRQ_MASK,
    input  logic                  GLOBAL_ENABLE,
    input  logic                  MSI_ENABLE,
    output logic                  MSI_REQ,
    output logic [MSI_VEC_W-1:0]  MSI_VECTOR,
    input  logic                  MSI_SENT,
    input  logic                  MSI_FAIL,
    output logic [IRQ_COUNT-1:0]  PENDING,
    output logic                  BUSY
`ifdef MSI_TIMEOUT_EN
    ,
    output logic                  TIMEOUT_ERR
`endif
);
    localparam int PW = (IRQ_COUNT > 1) ? $clog2(IRQ_COUNT) : 1;
    localparam int HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

    if (IRQ_COUNT < 1 || IRQ_COUNT > MAX_IRQ) begin : g_bad_count
        $error("pcie_msi_scheduler: IRQ_COUNT out of range");
    end

    logic [1:0]           state;
    logic [PW-1:0]        ptr;
    logic [PW-1:0]        cur_idx;
    logic [PW-1:0]        grant;
    logic                 grant_vld;
    logic [HW-1:0]        hold_cnt;
    logic [IRQ_COUNT-1:0] pend;
    logic [IRQ_COUNT-1:0] clr_mask;
    logic [IRQ_COUNT-1:0] set_mask;
    logic                 sched;
    logic                 req_done;
    logic                 req_fail;
    logic                 to_fire;

    rr_arbiter #(.N(IRQ_COUNT), .PW(PW)) u_arb (
        .req       (pend & IRQ_MASK),
        .ptr       (ptr),
        .grant     (grant),
        .grant_vld (grant_vld)
    );

    // A strobe in the same cycle as the timeout wins; SENT+FAIL together counts as FAIL.
    assign sched    = (state == ST_IDLE) && GLOBAL_ENABLE && MSI_ENABLE && grant_vld;
    assign req_done = (state == ST_REQ) && (MSI_SENT || MSI_FAIL || to_fire);
    assign req_fail = (state == ST_REQ) && (MSI_FAIL || (!MSI_SENT && to_fire));
    assign clr_mask = sched    ? (IRQ_COUNT'(1) << grant)   : '0;
    assign set_mask = req_fail ? (IRQ_COUNT'(1) << cur_idx) : '0;

    assign MSI_VECTOR = MSI_VEC_W'(cur_idx);
    assign PENDING    = pend;
    assign BUSY       = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            MSI_REQ  <= 1'b0;
            cur_idx  <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            pend     <= '0;
        end else begin
            // New strobes are OR-ed in last so a set coinciding with a grant survives.
            pend <= (pend & ~clr_mask) | set_mask | IRQ_IN;
            case (state)
                ST_IDLE: begin
                    if (sched) begin
                        MSI_REQ <= 1'b1;
                        cur_idx <= grant;
                        ptr     <= (int'(grant) == IRQ_COUNT - 1) ? '0 : grant + 1'b1;
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (req_done) begin
                        MSI_REQ  <= 1'b0;
                        hold_cnt <= '0;
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (int'(hold_cnt) + 1 >= HOLDOFF_CYCLES)
                        state <= ST_IDLE;
                    else
                        hold_cnt <= hold_cnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MSI_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;

    assign to_fire = (state == ST_REQ) && (int'(to_cnt) >= TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt      <= '0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            if (state != ST_REQ)
                to_cnt <= '0;
            else if (!to_fire)
                to_cnt <= to_cnt + 1'b1;
            if (to_fire && !MSI_SENT && !MSI_FAIL)
                TIMEOUT_ERR <= 1'b1;
        end
    end
`else
    assign to_fire = 1'b0;
`endif
endmodule
